// File: rtl/analyzer_scheduler.sv
// Round-robin front end and job sequencer for the three-unit number analyzer.
// Grants one of two requesters, runs the analyzer until every unit reports a
// terminal state (or the timer expires), returns the results over a
// valid/ready port, then drops go so the units return to their initial state.
module analyzer_scheduler #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_number,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_number,
    output logic             req1_ready,
    output logic             an_go,
    output logic [WIDTH-1:0] an_number,
    input  logic             an_even_done,
    input  logic             an_fib_done,
    input  logic             an_pal_done,
    input  logic             an_is_even,
    input  logic             an_is_fib,
    input  logic             an_is_pal,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_number,
    output logic [2:0]       rsp_flags,
    output logic             rsp_timeout,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESPOND,
        S_RELEASE
    } state_t;

    // Terminal count shared by the WAIT timeout and the RELEASE escape.
    localparam logic [TO_W-1:0] TIMER_TC = TO_W'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic            rr_fav;       // 0: requester 0 wins a tie
    logic [2:0]      seen;         // sticky per-unit completion
    logic [2:0]      res;          // captured result bits
    logic [TO_W-1:0] timer;
    logic            grant_any;
    logic            grant_id;
    logic [2:0]      done_in;
    logic [2:0]      res_in;
    logic [2:0]      seen_nxt;
    logic [2:0]      res_nxt;
    logic            all_done;
    logic            timer_tc;

    assign done_in   = {an_pal_done, an_fib_done, an_even_done};
    assign res_in    = {an_is_pal, an_is_fib, an_is_even};
    assign rsp_valid = (state == S_RESPOND);
    assign busy      = (state != S_IDLE);

    // Next state, arbitration, handshakes and capture of newly finished units.
    always_comb begin
        state_nxt  = state;
        grant_any  = 1'b0;
        grant_id   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        an_go      = 1'b0;
        seen_nxt   = seen | done_in;
        // A result is taken only on the first cycle a unit reports done.
        res_nxt    = res | (done_in & ~seen & res_in);
        all_done   = &seen_nxt;
        timer_tc   = (timer == TIMER_TC);
        case (state)
            S_IDLE: begin
                if (req0_valid && (!req1_valid || !rr_fav)) begin
                    grant_any  = 1'b1;
                    grant_id   = 1'b0;
                    req0_ready = 1'b1;
                    state_nxt  = S_LAUNCH;
                end else if (req1_valid) begin
                    grant_any  = 1'b1;
                    grant_id   = 1'b1;
                    req1_ready = 1'b1;
                    state_nxt  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                an_go     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                an_go = 1'b1;
                if (all_done || timer_tc) begin
                    state_nxt = S_RESPOND;
                end
            end
            S_RESPOND: begin
                // go stays high so the units hold their terminal state.
                an_go = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!(|done_in) || timer_tc) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Job datapath: operand latch, sticky flags, timer and response fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_fav      <= 1'b0;
            seen        <= '0;
            res         <= '0;
            timer       <= '0;
            an_number   <= '0;
            rsp_number  <= '0;
            rsp_id      <= 1'b0;
            rsp_flags   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        an_number  <= grant_id ? req1_number : req0_number;
                        rsp_number <= grant_id ? req1_number : req0_number;
                        rsp_id     <= grant_id;
                        rr_fav     <= ~grant_id;
                    end
                end
                S_LAUNCH: begin
                    seen  <= '0;
                    res   <= '0;
                    timer <= '0;
                end
                S_WAIT: begin
                    seen  <= seen_nxt;
                    res   <= res_nxt;
                    timer <= timer + TO_W'(1);
                    // Completion takes priority over a coincident timeout.
                    if (all_done) begin
                        rsp_flags   <= res_nxt;
                        rsp_timeout <= 1'b0;
                    end else if (timer_tc) begin
                        rsp_flags   <= res_nxt;
                        rsp_timeout <= 1'b1;
                    end
                end
                S_RESPOND: begin
                    if (rsp_ready) begin
                        timer <= '0;
                    end
                end
                S_RELEASE: begin
                    timer <= timer + TO_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_analyzer_scheduler.sv
// Scoreboard bench: stimulus pushes expected grants and job results into
// queues; a separate monitor pops and compares them on every response.
module tb_analyzer_scheduler;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_number, req1_number;
    logic             req0_ready, req1_ready;
    logic             an_go;
    logic [WIDTH-1:0] an_number;
    logic             an_even_done, an_fib_done, an_pal_done;
    logic             an_is_even, an_is_fib, an_is_pal;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_timeout, busy;
    logic [WIDTH-1:0] rsp_number;
    logic [2:0]       rsp_flags;

    analyzer_scheduler #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_number(req0_number), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_number(req1_number), .req1_ready(req1_ready),
        .an_go(an_go), .an_number(an_number),
        .an_even_done(an_even_done), .an_fib_done(an_fib_done), .an_pal_done(an_pal_done),
        .an_is_even(an_is_even), .an_is_fib(an_is_fib), .an_is_pal(an_is_pal),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_number(rsp_number), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [WIDTH-1:0] num; } grant_t;
    typedef struct { logic [2:0] flags; logic to; int lat; } res_t;

    int checks = 0;
    int errors = 0;

    grant_t           grant_q[$];
    res_t             exp_q[$];
    logic [WIDTH-1:0] src0[$], src1[$];
    int               grant_log[$];
    int               rr_model = 0;
    int               rdy_mode = 1;   // 0 hold low, 1 always high, 2 random
    bit               rand_mode = 0;

    // analyzer model state
    int d[3];
    bit r[3], pl[3], dn[3];
    int go_cnt, rel_cnt, lag, w;
    bit f_en = 0;
    int fd[3];
    bit fr[3], fpl[3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic set_force(input int d0, input int d1, input int d2,
                             input bit r0, input bit r1, input bit r2, input bit p0);
        fd[0] = d0; fd[1] = d1; fd[2] = d2;
        fr[0] = r0; fr[1] = r1; fr[2] = r2;
        fpl[0] = p0; fpl[1] = 1'b0; fpl[2] = 1'b0;
        f_en = 1'b1;
    endtask

    // Draw (or take forced) unit behaviour for a job and predict its result:
    // a unit counts only if it reports done within the TIMEOUT WAIT cycles.
    task new_job();
        res_t e;
        bit   all;
        int   mx;
        if (f_en) begin
            for (int u = 0; u < 3; u++) begin d[u] = fd[u]; r[u] = fr[u]; pl[u] = fpl[u]; end
            lag  = 0;
            f_en = 1'b0;
        end else begin
            for (int u = 0; u < 3; u++) begin
                case ($urandom % 8)
                    0:       d[u] = 0;
                    1:       d[u] = TIMEOUT;
                    default: d[u] = $urandom_range(1, TIMEOUT + 4);
                endcase
                r[u]  = 1'($urandom % 2);
                pl[u] = ($urandom % 4) == 0;
            end
            lag = $urandom_range(0, 4);
        end
        all = 1'b1; mx = 0; e.flags = 3'b000;
        for (int u = 0; u < 3; u++) begin
            if (d[u] != 0 && d[u] <= TIMEOUT) begin
                e.flags[u] = r[u];
                if (d[u] > mx) mx = d[u];
            end else begin
                all = 1'b0;
            end
        end
        e.to  = !all;
        e.lat = all ? mx + 1 : TIMEOUT + 1;
        exp_q.push_back(e);
    endtask

    // Analyzer model: done levels as a function of the WAIT cycle index.
    initial begin
        an_even_done = 0; an_fib_done = 0; an_pal_done = 0;
        an_is_even = 0; an_is_fib = 0; an_is_pal = 0;
        go_cnt = 0; rel_cnt = 0; lag = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                go_cnt = 0;
                an_even_done = 0; an_fib_done = 0; an_pal_done = 0;
            end else if (an_go) begin
                go_cnt++;
                rel_cnt = 0;
                if (go_cnt == 1) new_job();
                w = go_cnt - 1;
                for (int u = 0; u < 3; u++)
                    dn[u] = (d[u] != 0) && (pl[u] ? (w == d[u]) : (w >= d[u]));
                an_even_done = dn[0]; an_fib_done = dn[1]; an_pal_done = dn[2];
                an_is_even = dn[0] ? r[0] : 1'($urandom % 2);
                an_is_fib  = dn[1] ? r[1] : 1'($urandom % 2);
                an_is_pal  = dn[2] ? r[2] : 1'($urandom % 2);
            end else begin
                go_cnt = 0;
                rel_cnt++;
                if (rel_cnt > lag) begin
                    an_even_done = 0; an_fib_done = 0; an_pal_done = 0;
                end
            end
        end
    end

    // Response monitor.
    int     mgo = 0;
    bit     in_rsp = 0, after_hs = 0;
    grant_t cg;
    res_t   cr;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mgo = 0; in_rsp = 0; after_hs = 0;
            end else begin
                if (an_go) mgo++; else mgo = 0;
                if (after_hs) begin
                    chk("go_low_after_handshake", an_go, 0);
                    chk("valid_drop_after_handshake", rsp_valid, 0);
                    after_hs = 0;
                end
                if (rsp_valid) begin
                    if (!in_rsp) begin
                        if (grant_q.size() == 0 || exp_q.size() == 0) begin
                            chk("unexpected_response", 1, 0);
                        end else begin
                            cg = grant_q.pop_front();
                            cr = exp_q.pop_front();
                            chk("rsp_id", rsp_id, cg.id);
                            chk("rsp_number", rsp_number, cg.num);
                            chk("rsp_flags", rsp_flags, cr.flags);
                            chk("rsp_timeout", rsp_timeout, cr.to);
                            chk("rsp_latency", mgo - 1, cr.lat);
                        end
                        in_rsp = 1;
                    end else begin
                        chk("hold_id", rsp_id, cg.id);
                        chk("hold_number", rsp_number, cg.num);
                        chk("hold_flags", rsp_flags, cr.flags);
                        chk("hold_timeout", rsp_timeout, cr.to);
                    end
                    chk("respond_busy", busy, 1);
                    chk("respond_go", an_go, 1);
                    chk("respond_no_ready", req0_ready | req1_ready, 0);
                    if (rsp_ready) begin
                        in_rsp = 0;
                        after_hs = 1;
                    end
                end
            end
        end
    end

    // One cycle of stimulus: check arbitration at negedge, drive after posedge.
    task automatic tick();
        bit c0 = 0, c1 = 0;
        int exp_id, got;
        grant_t g;
        @(negedge clk);
        if (!reset) begin
            if (req0_ready || req1_ready) begin
                exp_id = (req0_valid && req1_valid) ? rr_model : (req0_valid ? 0 : 1);
                got    = req1_ready ? 1 : 0;
                chk("ready_exclusive", req0_ready & req1_ready, 0);
                chk("grant_id", got, exp_id);
                chk("grant_when_idle", busy, 0);
                g.id = got;
                if (got == 1 && src1.size() > 0) begin g.num = src1[0]; c1 = 1; end
                else if (got == 0 && src0.size() > 0) begin g.num = src0[0]; c0 = 1; end
                else begin g.num = '0; chk("grant_without_request", 1, 0); end
                grant_q.push_back(g);
                grant_log.push_back(got);
                rr_model = 1 - got;
            end else if (!busy && (req0_valid || req1_valid)) begin
                chk("missing_grant", 0, 1);
            end
        end
        @(posedge clk);
        #1;
        if (c0) void'(src0.pop_front());
        if (c1) void'(src1.pop_front());
        if (rand_mode) begin
            if (src0.size() < 3 && ($urandom % 6) == 0) src0.push_back($urandom);
            if (src1.size() < 3 && ($urandom % 6) == 0) src1.push_back($urandom);
        end
        req0_valid  = src0.size() > 0;
        req0_number = req0_valid ? src0[0] : $urandom;
        req1_valid  = src1.size() > 0;
        req1_number = req1_valid ? src1[0] : $urandom;
        rsp_ready   = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom % 2) : 1'b0;
    endtask

    function automatic bit quiet();
        return grant_q.size() == 0 && exp_q.size() == 0 && src0.size() == 0 &&
               src1.size() == 0 && !busy;
    endfunction

    task automatic run_until_quiet(input int maxc, input string nm);
        int n = 0;
        while (n < maxc && !quiet()) begin
            tick();
            n++;
        end
        chk(nm, quiet(), 1);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_go"}, an_go, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_rsp_valid"}, rsp_valid, 0);
        chk({nm, "_ready0"}, req0_ready, 0);
        chk({nm, "_ready1"}, req1_ready, 0);
        chk({nm, "_an_number"}, an_number, 0);
        chk({nm, "_rsp_fields"}, {rsp_id, rsp_number, rsp_flags, rsp_timeout}, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_number = '0; req1_number = '0;
        rsp_ready = 1'b1;
        #1;
        check_all_zero("reset_state");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // both requesters held valid: grants alternate starting with 0
        rdy_mode = 2;
        for (int i = 0; i < 4; i++) begin src0.push_back(21); src1.push_back(8); end
        run_until_quiet(600, "alternate_drain");
        chk("alternate_count", grant_log.size(), 8);
        for (int i = 0; i < grant_log.size(); i++) chk("alternate_order", grant_log[i], i % 2);

        // directed 2002 job: done at WAIT 2/7/9, results 1/0/0
        rdy_mode = 1;
        set_force(2, 7, 9, 1, 0, 0, 0);
        src0.push_back(2002);
        run_until_quiet(100, "directed_2002_drain");

        // response stalled for 20 cycles
        rdy_mode = 0;
        set_force(1, 2, 3, 0, 1, 1, 0);
        src0.push_back(77);
        n = 0;
        while (n < 100 && !rsp_valid) begin tick(); n++; end
        chk("stall_reached_respond", rsp_valid, 1);
        repeat (20) tick();
        rdy_mode = 1;
        run_until_quiet(100, "stall_drain");

        // fib never finishes: timeout with flags 101
        set_force(3, 0, 5, 1, 1, 1, 0);
        src1.push_back(123);
        run_until_quiet(100, "timeout_drain");

        // single-cycle even pulse at WAIT 1
        set_force(1, 3, 4, 1, 0, 1, 1);
        src0.push_back(4444);
        run_until_quiet(100, "pulse_drain");

        // reset in the middle of WAIT
        set_force(0, 0, 0, 1, 1, 1, 0);
        src0.push_back(999);
        n = 0;
        while (n < 50 && !an_go) begin tick(); n++; end
        chk("reset_test_launched", an_go, 1);
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        check_all_zero("mid_wait_reset");
        grant_q.delete(); exp_q.delete(); src0.delete(); src1.delete(); grant_log.delete();
        req0_valid = 0; req1_valid = 0;
        rr_model = 0;
        @(negedge clk);
        #1 reset = 1'b0;
        set_force(1, 1, 1, 0, 0, 0, 0);
        src1.push_back(5);
        run_until_quiet(100, "post_reset_drain");
        src0.push_back(6); src1.push_back(7);
        run_until_quiet(200, "post_reset_pair_drain");
        chk("post_reset_grants", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            chk("post_reset_first", grant_log[0], 1);
            chk("post_reset_rr_favours_0", grant_log[1], 0);
        end

        // randomized traffic
        rand_mode = 1;
        rdy_mode  = 2;
        repeat (1500) tick();
        rand_mode = 0;
        run_until_quiet(600, "random_drain");
        chk("random_jobs_seen", grant_log.size() > 20, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/analyzer_scheduler.md
Name: analyzer_scheduler

Overview:
- Sequencer and arbiter for the three-unit number analyzer (even, Fibonacci and palindrome sub-FSMs driven by a shared go/number pair).
- Accepts numbers from two requesters and grants them round-robin.
- Launches the analyzer, waits until all three units reach a terminal state, then returns the results over a valid/ready response port.
- Drops go after each job so the sub-FSMs return to their initial state, and bounds every job with a timeout.

Parameters:
- WIDTH, 32, width of the analysed number.
- TIMEOUT, 1023, maximum number of WAIT cycles before the job is aborted (at least 1).
- TO_W, 10, timer width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a number.
- req0_number  in  WIDTH  requester 0 operand.
- req0_ready  out  1  requester 0 transfer accepted this cycle.
- req1_valid  in  1  requester 1 has a number.
- req1_number  in  WIDTH  requester 1 operand.
- req1_ready  out  1  requester 1 transfer accepted this cycle.
- an_go  out  1  go to all three analyzer units.
- an_number  out  WIDTH  operand to the analyzer.
- an_even_done  in  1  even unit is in its terminal state (level).
- an_fib_done  in  1  Fibonacci unit is in its terminal state (level).
- an_pal_done  in  1  palindrome unit is in its terminal state (level).
- an_is_even  in  1  even result; valid while an_even_done is high.
- an_is_fib  in  1  Fibonacci result; valid while an_fib_done is high.
- an_is_pal  in  1  palindrome result; valid while an_pal_done is high.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester index of the response.
- rsp_number  out  WIDTH  operand echoed back.
- rsp_flags  out  3  {is_pal, is_fib, is_even}.
- rsp_timeout  out  1  job aborted by the timer.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; rr pointer favours requester 0; sticky flags and timer cleared. Reset in any state aborts the job with no response.
- FSM states: IDLE, LAUNCH, WAIT, RESPOND, RELEASE.
- IDLE:
  - an_go = 0.
  - Grant: if exactly one reqN_valid is high, grant it; if both are high, grant the requester the rr pointer favours.
  - reqN_ready is combinationally high only in IDLE, only for the granted requester, for exactly one cycle.
  - On grant: latch number and id into an_number, rsp_number and rsp_id; set the rr pointer to the other requester; go to LAUNCH.
  - No valid: stay in IDLE.
- LAUNCH: an_go = 1; clear the three sticky flags and the timer; go to WAIT.
- WAIT:
  - an_go = 1.
  - For each unit whose done input is high and whose sticky flag is clear: set the flag and capture that unit's result bit. Later changes on that unit's inputs are ignored.
  - The timer increments every WAIT cycle.
  - When all three flags are set (counting captures made this cycle), go to RESPOND with timeout = 0.
  - Otherwise, when the timer reaches TIMEOUT-1, go to RESPOND with timeout = 1; flag bits of incomplete units are 0.
  - Completion and timeout in the same cycle: completion wins, so rsp_timeout = 0.
- RESPOND:
  - an_go = 1, so the analyzer holds its terminal state.
  - rsp_valid = 1; rsp_id, rsp_number, rsp_flags and rsp_timeout are stable until the handshake.
  - When rsp_valid && rsp_ready: go to RELEASE. rsp_valid drops on the next cycle.
- RELEASE:
  - an_go = 0.
  - Stay at least one cycle, and until all three done inputs are low.
  - If the done inputs have not all fallen within TIMEOUT cycles, go to IDLE anyway; the next job's LAUNCH clears the flags.
  - Then go to IDLE.
- Done inputs are ignored outside WAIT and RELEASE.
- an_number holds its latched value from the grant until the next grant; it is never cleared between jobs.
- Latency:
  - Grant in cycle T: LAUNCH at T+1, first WAIT cycle at T+2.
  - If the last done is first seen in WAIT cycle W, rsp_valid rises at W+1.
  - Minimum request-to-response time is 3 cycles.
  - Minimum time from the response handshake to the next grant is 2 cycles (RELEASE, then IDLE).
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…

Test Plan:
- req0 = 2002, analyzer model asserts even/fib/pal done at WAIT cycles 2/7/9 with results 1/0/0 → rsp_valid at WAIT cycle 10; rsp_id = 0, rsp_number = 2002, rsp_flags = 3'b001, rsp_timeout = 0; an_go low for at least 1 cycle after the handshake.
- After reset, both valid with req0 = 21 and req1 = 8, held valid → grant order 0,1,0,1; rsp_id alternates; req1_ready is never high in the same cycle as req0_ready.
- rsp_ready held low for 20 cycles in RESPOND → response fields constant; busy = 1; req0_ready and req1_ready stay 0; an_go stays 1.
- TIMEOUT = 16, an_fib_done never asserts, even and pal done with result 1 → rsp_timeout = 1 exactly 16 cycles after WAIT entry; rsp_flags = 3'b101.
- an_even_done pulses for a single cycle at WAIT cycle 1 with an_is_even = 1, then drops → sticky capture holds; final rsp_flags[0] = 1.
- reset pulsed mid-WAIT (asynchronous, between edges) → outputs 0 immediately; next req1 = 5 is granted (no stale response); the rr pointer then favours requester 0.
